// File: rtl/icache_pkg.sv
// Shared types and derived-width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REQ,
        ST_FILL,
        ST_RESP
    } state_e;

    function automatic int idx_bits(input int n_lines);
        return $clog2(n_lines);
    endfunction

    function automatic int tag_bits(input int w_addr, input int n_bytealign, input int n_lines);
        return w_addr - n_bytealign - $clog2(n_lines);
    endfunction

    function automatic int beat_count(input int w_data, input int w_mem);
        return w_data / w_mem;
    endfunction

    function automatic int cnt_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-queue and memory-fill signal bundle; slave = cache side, master = IFQ/memory side.
interface icache_if #(
    parameter int W_DATA = 128,
    parameter int W_ADDR = 32,
    parameter int W_MEM  = 32
);
    logic [W_ADDR-1:0] ifq_pcin;
    logic              ifq_ren;
    logic              ifq_abort;
    logic              ifq_ready;
    logic [W_DATA-1:0] ifq_dout;
    logic              ifq_dout_valid;
    logic              ic_flush;
    logic              mem_req;
    logic [W_ADDR-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [W_MEM-1:0]  mem_rdata;
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;

    modport slave (
        input  ifq_pcin, ifq_ren, ifq_abort, ic_flush, mem_gnt, mem_rvalid, mem_rdata,
        output ifq_ready, ifq_dout, ifq_dout_valid, mem_req, mem_addr, perf_hits, perf_misses
    );

    modport master (
        output ifq_pcin, ifq_ren, ifq_abort, ic_flush, mem_gnt, mem_rvalid, mem_rdata,
        input  ifq_ready, ifq_dout, ifq_dout_valid, mem_req, mem_addr, perf_hits, perf_misses
    );
endinterface

// File: rtl/icache_data_ram.sv
// Single-write, single synchronous-read line store; the cache keeps tag alongside data.
module icache_data_ram #(
    parameter  int W     = 128,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: one-cycle hits, beat-wise line refill on miss.
// Hit/miss counters are built only when ICACHE_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | ready for a fetch; clears sticky abort/flush
// LOOKUP | tag/valid compare on the RAM read data; hits may chain
// REQ    | mem_req held until mem_gnt
// FILL   | collect BEATS beats into the fill buffer, install on last
// RESP   | present the fill buffer unless aborted
module icache_dm
    import icache_pkg::*;
#(
    parameter int W_DATA      = 128,
    parameter int W_ADDR      = 32,
    parameter int N_BYTEALIGN = 4,
    parameter int N_LINES     = 64,
    parameter int W_MEM       = 32
) (
    input logic     clk,
    input logic     reset,
    icache_if.slave bus
);
    localparam int IDX   = idx_bits(N_LINES);
    localparam int TAG   = tag_bits(W_ADDR, N_BYTEALIGN, N_LINES);
    localparam int BEATS = beat_count(W_DATA, W_MEM);
    localparam int CNT   = cnt_bits(BEATS);
    localparam int W_RAM = W_DATA + TAG;

    state_e             state_q, state_d;
    logic [TAG-1:0]     tag_q, tag_d;
    logic [IDX-1:0]     idx_q, idx_d;
    logic [CNT-1:0]     cnt_q, cnt_d;
    logic [W_DATA-1:0]  fill_q, fill_d;
    logic [W_DATA-1:0]  dout_q, dout_d;
    logic [N_LINES-1:0] valid_q, valid_d;
    logic               aborted_q, aborted_d;
    logic               flush_pend_q, flush_pend_d;
    logic               mem_req_q, mem_req_d;
    logic [W_ADDR-1:0]  mem_addr_q, mem_addr_d;

    logic               ram_we;
    logic [W_RAM-1:0]   ram_wdata, ram_rdata;
    logic               hit, ready, accept, last_beat, dout_valid;

    logic unused_low_pc;
    assign unused_low_pc = ^bus.ifq_pcin[N_BYTEALIGN-1:0];

    icache_data_ram #(.W(W_RAM), .DEPTH(N_LINES)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (ram_wdata),
        .re    (accept),
        .raddr (bus.ifq_pcin[N_BYTEALIGN +: IDX]),
        .rdata (ram_rdata)
    );

    assign hit       = (state_q == ST_LOOKUP) && valid_q[idx_q]
                       && (ram_rdata[W_RAM-1 -: TAG] == tag_q);
    assign ready     = (state_q == ST_IDLE) || hit;
    assign accept    = bus.ifq_ren && !bus.ifq_abort && ready;
    assign last_beat = (state_q == ST_FILL) && bus.mem_rvalid && (cnt_q == CNT'(BEATS - 1));
    assign dout_valid = (hit || (state_q == ST_RESP && !aborted_q)) && !bus.ifq_abort;

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        valid_d      = valid_q;
        aborted_d    = aborted_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ram_we       = 1'b0;
        ram_wdata    = {tag_q, fill_q};
        dout_d       = dout_valid ? (hit ? ram_rdata[W_DATA-1:0] : fill_q) : dout_q;

        if (accept) begin
            tag_d = bus.ifq_pcin[W_ADDR-1 -: TAG];
            idx_d = bus.ifq_pcin[N_BYTEALIGN +: IDX];
        end

        unique case (state_q)
            ST_IDLE: begin
                aborted_d    = 1'b0;
                flush_pend_d = 1'b0;
                if (bus.ic_flush) valid_d = '0;
                if (accept) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (bus.ic_flush) valid_d = '0;
                if (hit) begin
                    state_d = accept ? ST_LOOKUP : ST_IDLE;
                end else begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag_q, idx_q, {N_BYTEALIGN{1'b0}}};
                    // a redirect seen while the miss is detected also cancels its response
                    aborted_d  = bus.ifq_abort;
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt) begin
                    state_d   = ST_FILL;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            ST_FILL: begin
                if (bus.mem_rvalid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT'(b)) fill_d[b*W_MEM +: W_MEM] = bus.mem_rdata;
                    end
                    cnt_d = cnt_q + CNT'(1);
                end
                if (last_beat) begin
                    ram_we          = 1'b1;
                    ram_wdata       = {tag_q, fill_d};
                    valid_d[idx_q]  = 1'b1;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                // flush deferred from the refill window lands here, after the install
                if (flush_pend_q || bus.ic_flush) valid_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q inside {ST_REQ, ST_FILL, ST_RESP}) begin
            if (bus.ifq_abort) aborted_d = 1'b1;
            if (bus.ic_flush && state_q != ST_RESP) flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            valid_q      <= '0;
            aborted_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            aborted_q    <= aborted_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign bus.ifq_ready      = ready;
    assign bus.ifq_dout       = dout_d;
    assign bus.ifq_dout_valid = dout_valid;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_addr       = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d;
    logic        miss;

    assign miss = (state_q == ST_LOOKUP) && !hit;

    always_comb begin
        hits_d   = hits_q + 32'(hit);
        misses_d = misses_q + 32'(miss);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign bus.perf_hits   = hits_q;
    assign bus.perf_misses = misses_q;
`else
    assign bus.perf_hits   = '0;
    assign bus.perf_misses = '0;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: vector table of fetches plus hand-written abort/flush/reset sequences.
module tb_icache_dm;
    localparam int BEATS = 4;
`ifdef ICACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [127:0] LA = 128'h44444444_33333333_22222222_11111111; // 0x100
    localparam logic [127:0] LB = 128'h44444844_33333733_22222622_11111511; // 0x500
    localparam logic [127:0] LC = 128'h44444544_33333433_22222322_11111211; // 0x200
    localparam logic [127:0] LD = 128'h44444944_33333833_22222722_11111611; // 0x600
    localparam logic [127:0] LE = 128'h44444a44_33333933_22222822_11111711; // 0x700
    localparam logic [127:0] LF = 128'h44444644_33333533_22222422_11111311; // 0x300

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   nh = 0;
    int   nm = 0;

    icache_if #(.W_DATA(128), .W_ADDR(32), .W_MEM(32)) bus ();

    icache_dm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        bit           miss;
        logic [31:0]  maddr;
        logic [127:0] line;
    } vec_t;

    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_val(input logic [31:0] a, input int k);
        return 32'h11111111 * (k + 1) + ({a[31:4], 4'b0} - 32'h100);
    endfunction

    // one fetch; on a miss plays memory: 1 grant-wait cycle, beats with a bubble before beat 2
    task automatic fetch(input logic [31:0] addr, input int abort_beat, input int flush_beat,
                         output bit miss, output logic [31:0] maddr,
                         output logic rvld, output logic [127:0] rline);
        miss = 1'b0; maddr = '0; rvld = 1'b0; rline = '0;
        @(negedge clk);
        bus.ifq_pcin = addr; bus.ifq_ren = 1'b1; #1;
        chk1("ready_at_req", bus.ifq_ready, 1'b1);
        @(negedge clk);
        bus.ifq_ren = 1'b0; #1;
        if (bus.ifq_dout_valid === 1'b1) begin
            rvld = 1'b1; rline = bus.ifq_dout;
            return;
        end
        miss = 1'b1;
        chk1("no_req_in_lookup", bus.mem_req, 1'b0);
        @(negedge clk); #1;
        chk1("req_at_n2", bus.mem_req, 1'b1);
        maddr = bus.mem_addr;
        if (bus.mem_req !== 1'b1) return;
        @(negedge clk); #1;
        chk1("req_held", bus.mem_req, 1'b1);
        bus.mem_gnt = 1'b1;
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus.mem_rvalid = 1'b0; bus.ifq_abort = 1'b0; bus.ic_flush = 1'b0;
                @(negedge clk);
            end
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beat_val(addr, k);
            bus.ifq_abort  = (k == abort_beat);
            bus.ic_flush   = (k == flush_beat);
            if (k == 0) begin
                #1;
                chk1("req_dropped", bus.mem_req, 1'b0);
            end
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.ifq_abort = 1'b0; bus.ic_flush = 1'b0; #1;
        rvld  = bus.ifq_dout_valid;
        rline = bus.ifq_dout;
    endtask

    bit           m;
    logic [31:0]  ma;
    logic         v;
    logic [127:0] ln;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h100, 1'b1, 32'h100, LA};
        vecs[1] = '{32'h10c, 1'b0, 32'h0,   LA};
        vecs[2] = '{32'h500, 1'b1, 32'h500, LB};
        vecs[3] = '{32'h104, 1'b1, 32'h100, LA};
        vecs[4] = '{32'h20c, 1'b1, 32'h200, LC};
        vecs[5] = '{32'h200, 1'b0, 32'h0,   LC};
        vecs[6] = '{32'h508, 1'b1, 32'h500, LB};
        vecs[7] = '{32'h50c, 1'b0, 32'h0,   LB};

        reset = 1'b1;
        bus.ifq_pcin = '0; bus.ifq_ren = 1'b0; bus.ifq_abort = 1'b0; bus.ic_flush = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0; #1;
        chk1("rst_ready", bus.ifq_ready, 1'b1);
        chk1("rst_dout_valid", bus.ifq_dout_valid, 1'b0);
        chkw("rst_dout", bus.ifq_dout, '0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chkw("rst_mem_addr", 128'(bus.mem_addr), '0);
        chkw("rst_perf_hits", 128'(bus.perf_hits), '0);
        chkw("rst_perf_misses", 128'(bus.perf_misses), '0);

        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].addr, -1, -1, m, ma, v, ln);
            chk1($sformatf("vec%0d_miss", i), m, vecs[i].miss);
            chk1($sformatf("vec%0d_valid", i), v, 1'b1);
            chkw($sformatf("vec%0d_line", i), ln, vecs[i].line);
            if (vecs[i].miss) chkw($sformatf("vec%0d_maddr", i), 128'(ma), 128'(vecs[i].maddr));
            if (vecs[i].miss) nm++; else nh++;
        end

        // back-to-back hits on the line now at index 16
        @(negedge clk);
        bus.ifq_pcin = 32'h500; bus.ifq_ren = 1'b1;
        @(negedge clk);
        bus.ifq_pcin = 32'h504; #1;
        chk1("b2b_valid_n1", bus.ifq_dout_valid, 1'b1);
        chk1("b2b_ready_n1", bus.ifq_ready, 1'b1);
        chkw("b2b_line_n1", bus.ifq_dout, LB);
        @(negedge clk);
        bus.ifq_ren = 1'b0; #1;
        chk1("b2b_valid_n2", bus.ifq_dout_valid, 1'b1);
        chkw("b2b_line_n2", bus.ifq_dout, LB);
        chk1("b2b_no_req_n2", bus.mem_req, 1'b0);
        @(negedge clk); #1;
        chk1("b2b_no_req_n3", bus.mem_req, 1'b0);
        chk1("b2b_idle_valid", bus.ifq_dout_valid, 1'b0);
        chkw("b2b_dout_hold", bus.ifq_dout, LB);
        nh += 2;

        // abort together with a request: not accepted, index 16 not evicted
        @(negedge clk);
        bus.ifq_pcin = 32'h900; bus.ifq_ren = 1'b1; bus.ifq_abort = 1'b1;
        @(negedge clk);
        bus.ifq_ren = 1'b0; bus.ifq_abort = 1'b0; #1;
        chk1("abreq_no_valid", bus.ifq_dout_valid, 1'b0);
        chk1("abreq_ready", bus.ifq_ready, 1'b1);
        @(negedge clk); #1;
        chk1("abreq_no_req", bus.mem_req, 1'b0);
        fetch(32'h504, -1, -1, m, ma, v, ln);
        chk1("abreq_then_hit", m, 1'b0);
        chkw("abreq_then_line", ln, LB);
        nh++;

        // abort during FILL beat 2: line installed, response suppressed
        fetch(32'h600, 2, -1, m, ma, v, ln);
        chk1("abfill_miss", m, 1'b1);
        chk1("abfill_no_valid", v, 1'b0);
        nm++;
        fetch(32'h600, -1, -1, m, ma, v, ln);
        chk1("abfill_rehit", m, 1'b0);
        chk1("abfill_rehit_valid", v, 1'b1);
        chkw("abfill_rehit_line", ln, LD);
        nh++;

        // flush during FILL: response delivered, line left invalid
        fetch(32'h700, -1, 1, m, ma, v, ln);
        chk1("flfill_miss", m, 1'b1);
        chk1("flfill_valid", v, 1'b1);
        chkw("flfill_line", ln, LE);
        nm++;
        fetch(32'h700, -1, -1, m, ma, v, ln);
        chk1("flfill_remiss", m, 1'b1);
        chkw("flfill_remiss_line", ln, LE);
        nm++;
        fetch(32'h700, -1, -1, m, ma, v, ln);
        chk1("flidle_pre_hit", m, 1'b0);
        nh++;
        @(negedge clk);
        bus.ic_flush = 1'b1;
        @(negedge clk);
        bus.ic_flush = 1'b0;
        fetch(32'h700, -1, -1, m, ma, v, ln);
        chk1("flidle_miss", m, 1'b1);
        chk1("flidle_valid", v, 1'b1);
        nm++;
        chkw("perf_hits", 128'(bus.perf_hits), PERF ? 128'(nh) : '0);
        chkw("perf_misses", 128'(bus.perf_misses), PERF ? 128'(nm) : '0);

        // reset at FILL beat 1, then stray beats while idle
        @(negedge clk);
        bus.ifq_pcin = 32'h300; bus.ifq_ren = 1'b1;
        @(negedge clk);
        bus.ifq_ren = 1'b0;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = beat_val(32'h300, 0);
        @(negedge clk);
        bus.mem_rdata = beat_val(32'h300, 1); reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.mem_rdata = 32'hdeadbeef; #1;
        chk1("rstfill_ready", bus.ifq_ready, 1'b1);
        chk1("rstfill_no_req", bus.mem_req, 1'b0);
        chk1("rstfill_no_valid", bus.ifq_dout_valid, 1'b0);
        @(negedge clk);
        bus.mem_rdata = 32'hcafef00d; #1;
        chk1("stray_no_valid", bus.ifq_dout_valid, 1'b0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0; #1;
        chk1("stray_no_valid2", bus.ifq_dout_valid, 1'b0);
        chkw("rstfill_dout", bus.ifq_dout, '0);
        chkw("rstfill_perf_hits", 128'(bus.perf_hits), '0);
        chkw("rstfill_perf_misses", 128'(bus.perf_misses), '0);
        fetch(32'h300, -1, -1, m, ma, v, ln);
        chk1("postrst_miss", m, 1'b1);
        chkw("postrst_maddr", 128'(ma), 128'(32'h300));
        chkw("postrst_line", ln, LF);
        fetch(32'h500, -1, -1, m, ma, v, ln);
        chk1("postrst_invalidated", m, 1'b1);
        chkw("postrst_line_b", ln, LB);
        chkw("postrst_perf_hits", 128'(bus.perf_hits), '0);
        chkw("postrst_perf_misses", 128'(bus.perf_misses), PERF ? 128'(2) : '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
